// File: rtl/u400_pkg.sv
// Shared definitions for the U400 SDRAM controller: init/refresh FSM states,
// default 40 MHz timing, and the SDRAM command encoding used by the sequencer.
package u400_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT_PRE = 3'd1,
        INIT_REF = 3'd2,
        INIT_MRS = 3'd3,
        RUN      = 3'd4
    } u400_state_e;

    // Timing defaults in CLK40 cycles
    localparam int U400_INIT_WAIT      = 4000;   // 100 us power-up wait
    localparam int U400_REF_INTERVAL   = 312;    // 7.8 us refresh interval
    localparam int U400_INIT_REFRESHES = 8;
    localparam int U400_MAX_PEND       = 8;
    localparam int U400_URGENT_LVL     = 6;
    localparam int U400_PEND_W         = 4;

    // {CS#, RAS#, CAS#, WE#}
    typedef enum logic [3:0] {
        CMD_MRS       = 4'b0000,
        CMD_AUTO_REF  = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b0111,
        CMD_DESELECT  = 4'b1111
    } sdram_cmd_e;

endpackage

// File: rtl/u400_ref_backlog.sv
// Refresh backlog: saturating up/down counter of owed auto-refreshes, with
// a sticky overflow flag and an urgency compare for CPU pre-emption.
module u400_ref_backlog
    import u400_pkg::*;
#(
    parameter int MAX_PEND   = U400_MAX_PEND,
    parameter int URGENT_LVL = U400_URGENT_LVL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [U400_PEND_W-1:0] load_val,
    input  logic                   tick,
    input  logic                   ack,
    output logic [U400_PEND_W-1:0] pend_cnt,
    output logic                   ref_req,
    output logic                   ref_urgent,
    output logic                   ref_ovf
);

    localparam logic [U400_PEND_W-1:0] MAX_V = U400_PEND_W'(MAX_PEND);
    localparam logic [U400_PEND_W-1:0] URG_V = U400_PEND_W'(URGENT_LVL);

    logic [U400_PEND_W-1:0] cnt_q;
    logic                   ovf_q;
    logic                   ack_eff;

    // An ack with nothing owed never underflows the count
    assign ack_eff = ack && (cnt_q != '0);

    // Backlog update: a tick and an effective ack in the same cycle cancel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && !ack_eff) begin
            if (cnt_q == MAX_V) ovf_q <= 1'b1;
            else                cnt_q <= cnt_q + U400_PEND_W'(1);
        end else if (ack_eff && !tick) begin
            cnt_q <= cnt_q - U400_PEND_W'(1);
        end
    end

    // Status decoded purely from registered state
    always_comb begin
        pend_cnt   = cnt_q;
        ref_req    = (cnt_q != '0);
        ref_urgent = (cnt_q >= URG_V);
        ref_ovf    = ovf_q;
    end

endmodule

// File: rtl/u400_sdram_refresh.sv
// SDRAM power-up initialisation and periodic refresh-request generator.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   PWR_WAIT | counting the power-up wait after reset
//   INIT_PRE | requesting PRECHARGE ALL
//   INIT_REF | draining the init auto-refresh burst through the backlog
//   INIT_MRS | requesting MODE REGISTER SET
//   RUN      | SDRAM ready; periodic refresh ticks feed the backlog
module u400_sdram_refresh
    import u400_pkg::*;
#(
    parameter int INIT_WAIT      = U400_INIT_WAIT,
    parameter int REF_INTERVAL   = U400_REF_INTERVAL,
    parameter int INIT_REFRESHES = U400_INIT_REFRESHES,
    parameter int MAX_PEND       = U400_MAX_PEND,
    parameter int URGENT_LVL     = U400_URGENT_LVL
) (
    input  logic                   CLK40,
    input  logic                   RESETn,
    input  logic                   PRE_ACK,
    input  logic                   REF_ACK,
    input  logic                   MRS_ACK,
    output logic                   PRE_REQ,
    output logic                   REF_REQ,
    output logic                   REF_URGENT,
    output logic                   MRS_REQ,
    output logic                   SDRAM_RDY,
    output logic                   REF_OVF,
    output logic [U400_PEND_W-1:0] PEND_CNT
);

    localparam int WAIT_W = (INIT_WAIT    > 1) ? $clog2(INIT_WAIT)    : 1;
    localparam int IVL_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    u400_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [IVL_W-1:0]  ivl_q;
    logic              wait_done;
    logic              tick;
    logic              bl_load;
    logic              bl_ack;

    assign wait_done = (wait_q == WAIT_W'(INIT_WAIT - 1));
    assign tick      = (state_q == RUN) && (ivl_q == IVL_W'(REF_INTERVAL - 1));
    // Refresh acks only matter while refreshes are being requested by us
    assign bl_ack    = REF_ACK && ((state_q == INIT_REF) || (state_q == RUN));

    // State register
    always_ff @(posedge CLK40) begin
        if (!RESETn) state_q <= PWR_WAIT;
        else         state_q <= state_d;
    end

    // Power-up wait counter, only advances in PWR_WAIT
    always_ff @(posedge CLK40) begin
        if (!RESETn)                  wait_q <= '0;
        else if (state_q == PWR_WAIT) wait_q <= wait_q + WAIT_W'(1);
    end

    // Refresh interval counter; held at zero outside RUN so RUN entry starts a fresh interval
    always_ff @(posedge CLK40) begin
        if (!RESETn)             ivl_q <= '0;
        else if (state_q != RUN) ivl_q <= '0;
        else if (tick)           ivl_q <= '0;
        else                     ivl_q <= ivl_q + IVL_W'(1);
    end

    // Next-state logic and backlog load strobe
    always_comb begin
        state_d = state_q;
        bl_load = 1'b0;
        case (state_q)
            PWR_WAIT: if (wait_done) state_d = INIT_PRE;
            INIT_PRE: if (PRE_ACK) begin
                state_d = INIT_REF;
                bl_load = 1'b1;
            end
            // Leave on the edge that retires the last owed refresh
            INIT_REF: if ((PEND_CNT == '0) ||
                          (REF_ACK && (PEND_CNT == U400_PEND_W'(1)))) state_d = INIT_MRS;
            INIT_MRS: if (MRS_ACK) state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = PWR_WAIT;
        endcase
    end

    // Request levels decoded from state
    always_comb begin
        PRE_REQ   = (state_q == INIT_PRE);
        MRS_REQ   = (state_q == INIT_MRS);
        SDRAM_RDY = (state_q == RUN);
    end

    u400_ref_backlog #(
        .MAX_PEND   (MAX_PEND),
        .URGENT_LVL (URGENT_LVL)
    ) u_backlog (
        .clk        (CLK40),
        .rst_n      (RESETn),
        .load       (bl_load),
        .load_val   (U400_PEND_W'(INIT_REFRESHES)),
        .tick       (tick),
        .ack        (bl_ack),
        .pend_cnt   (PEND_CNT),
        .ref_req    (REF_REQ),
        .ref_urgent (REF_URGENT),
        .ref_ovf    (REF_OVF)
    );

endmodule

// File: tb/tb_u400_sdram_refresh.sv
// Bench for u400_sdram_refresh: directed sequences plus random acks, every
// cycle compared against a behavioural model of the init/refresh rules.
module tb_u400_sdram_refresh;

    localparam int INIT_WAIT      = 20;
    localparam int REF_INTERVAL   = 10;
    localparam int INIT_REFRESHES = 8;
    localparam int MAX_PEND       = 8;
    localparam int URGENT_LVL     = 6;

    localparam int M_WAIT = 0, M_PRE = 1, M_REF = 2, M_MRS = 3, M_RUN = 4;

    logic       CLK40 = 1'b0;
    logic       RESETn, PRE_ACK, REF_ACK, MRS_ACK;
    logic       PRE_REQ, REF_REQ, REF_URGENT, MRS_REQ, SDRAM_RDY, REF_OVF;
    logic [3:0] PEND_CNT;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_mode, m_since, m_backlog, m_age;
    bit m_ovf;

    u400_sdram_refresh #(
        .INIT_WAIT      (INIT_WAIT),
        .REF_INTERVAL   (REF_INTERVAL),
        .INIT_REFRESHES (INIT_REFRESHES),
        .MAX_PEND       (MAX_PEND),
        .URGENT_LVL     (URGENT_LVL)
    ) dut (
        .CLK40      (CLK40),
        .RESETn     (RESETn),
        .PRE_ACK    (PRE_ACK),
        .REF_ACK    (REF_ACK),
        .MRS_ACK    (MRS_ACK),
        .PRE_REQ    (PRE_REQ),
        .REF_REQ    (REF_REQ),
        .REF_URGENT (REF_URGENT),
        .MRS_REQ    (MRS_REQ),
        .SDRAM_RDY  (SDRAM_RDY),
        .REF_OVF    (REF_OVF),
        .PEND_CNT   (PEND_CNT)
    );

    always #5 CLK40 = ~CLK40;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge(input bit rn, input bit pa, input bit ra, input bit ma);
        bit tk, took;
        if (!rn) begin
            m_mode = M_WAIT; m_since = 0; m_backlog = 0; m_ovf = 0; m_age = 0;
            return;
        end
        case (m_mode)
            M_WAIT: begin
                m_since++;
                if (m_since == INIT_WAIT) m_mode = M_PRE;
            end
            M_PRE: if (pa) begin
                m_mode = M_REF;
                m_backlog = INIT_REFRESHES;
            end
            M_REF: begin
                if (ra && m_backlog > 0) m_backlog--;
                if (m_backlog == 0) m_mode = M_MRS;
            end
            M_MRS: if (ma) begin
                m_mode = M_RUN;
                m_age = 0;
            end
            default: begin
                m_age++;
                tk   = (m_age % REF_INTERVAL) == 0;
                took = ra && (m_backlog > 0);
                if (tk && !took) begin
                    if (m_backlog == MAX_PEND) m_ovf = 1;
                    else m_backlog++;
                end else if (took && !tk) begin
                    m_backlog--;
                end
            end
        endcase
    endtask

    function automatic logic [15:0] exp_vec();
        logic [15:0] v;
        v = {6'd0, (m_mode == M_PRE), (m_backlog != 0), (m_backlog >= URGENT_LVL),
             (m_mode == M_MRS), (m_mode == M_RUN), m_ovf, 4'(m_backlog)};
        return v;
    endfunction

    function automatic logic [15:0] obs_vec();
        logic [15:0] v;
        v = {6'd0, PRE_REQ, REF_REQ, REF_URGENT, MRS_REQ, SDRAM_RDY, REF_OVF, PEND_CNT};
        return v;
    endfunction

    // Drive inputs, clock once, compare all outputs to the model
    task automatic step(input bit rn, input bit pa, input bit ra, input bit ma);
        RESETn = rn; PRE_ACK = pa; REF_ACK = ra; MRS_ACK = ma;
        @(posedge CLK40);
        model_edge(rn, pa, ra, ma);
        #1;
        chk("outputs", obs_vec(), exp_vec());
    endtask

    // Release reset and measure clocks until PRE_REQ, with spurious acks
    task automatic power_up(input bit spurious);
        int n;
        n = 0;
        do begin
            if (spurious) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
            else          step(1, 0, 0, 0);
            n++;
        end while (!PRE_REQ && n < 40);
        chk("pre_latency", 16'(n), 16'(INIT_WAIT));
    endtask

    task automatic run_init();
        for (int i = 0; i < 3; i++) step(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("pre_hold", 16'({PRE_REQ, PEND_CNT}), 16'({1'b1, 4'd0}));
        step(1, 1, 0, 0);
        chk("init_load", 16'(PEND_CNT), 16'(INIT_REFRESHES));
        for (int i = 0; i < INIT_REFRESHES; i++) begin
            step(1, 0, 1, 0);
            chk("init_pend", 16'(PEND_CNT), 16'(INIT_REFRESHES - 1 - i));
        end
        chk("mrs_req", 16'({MRS_REQ, SDRAM_RDY}), 16'({1'b1, 1'b0}));
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("sdram_rdy", 16'({SDRAM_RDY, MRS_REQ}), 16'({1'b1, 1'b0}));
    endtask

    initial begin
        int guard;
        RESETn = 0; PRE_ACK = 0; REF_ACK = 0; MRS_ACK = 0;
        model_edge(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("reset_vec", obs_vec(), 16'd0);

        // Power-up and init with spurious acks in PWR_WAIT / INIT_PRE
        power_up(1);
        run_init();

        // Free-running ticks with no acks, through saturation
        for (int i = 1; i <= 95; i++) begin
            step(1, 0, 0, 0);
            if (i % REF_INTERVAL == 0) begin
                chk("tick_pend", 16'(PEND_CNT), 16'((i / 10 > 8) ? 8 : i / 10));
                chk("urgent", 16'(REF_URGENT), 16'(i / 10 >= 6));
                chk("ovf", 16'(REF_OVF), 16'(i / 10 >= 9));
            end
        end

        // Work backlog down to 5 between ticks, then reset for one clock
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        chk("pre_reset", 16'({REF_OVF, PEND_CNT}), 16'({1'b1, 4'd5}));
        step(0, 0, 0, 0);
        chk("mid_reset", obs_vec(), 16'd0);
        power_up(0);
        run_init();

        // Ack with nothing owed
        step(1, 0, 1, 0);
        chk("ack_at_zero", 16'({REF_REQ, PEND_CNT}), 16'd0);

        // Reach backlog 3 then ack on the tick edge
        guard = 0;
        while (!(m_backlog == 3 && (m_age + 1) % REF_INTERVAL == 0) && guard < 100) begin
            step(1, 0, 0, 0);
            guard++;
        end
        chk("reach_3", 16'(PEND_CNT), 16'd3);
        step(1, 0, 1, 0);
        chk("tick_ack", 16'(PEND_CNT), 16'd3);

        // Random ack traffic in RUN, with an occasional reset and re-init
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(0, 0, 0, 0);
                power_up(1);
                run_init();
            end else begin
                step(1, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/u400_sdram_refresh.md
Name: u400_sdram_refresh

Overview:
- Power-up initialisation and refresh-request generator for the 68040 local-bus SDRAM.
- Sits directly upstream of the U400 SDRAM command sequencer.
- Times the JEDEC power-up wait, then requests precharge-all, the init auto-refresh burst and the mode-register set.
- In normal running it issues periodic refresh requests, with a postponed-refresh backlog and an urgency flag so the sequencer can pre-empt CPU cycles.

Parameters:
- INIT_WAIT, 4000: clocks of power-up wait after reset (100 us at 40 MHz).
- REF_INTERVAL, 312: clocks between refresh ticks (7.8 us at 40 MHz).
- INIT_REFRESHES, 8: auto-refreshes requested during initialisation.
- MAX_PEND, 8: backlog saturation limit (JEDEC postponement limit).
- URGENT_LVL, 6: backlog at or above which REF_URGENT asserts.

Ports:
- CLK40  in  1  local-bus clock, all state on rising edge.
- RESETn  in  1  synchronous, active-low reset.
- PRE_ACK  in  1  one-cycle pulse: sequencer issued PRECHARGE ALL.
- REF_ACK  in  1  one-cycle pulse: sequencer issued AUTO REFRESH.
- MRS_ACK  in  1  one-cycle pulse: sequencer issued MODE REGISTER SET.
- PRE_REQ  out  1  precharge-all request (level).
- REF_REQ  out  1  refresh request (level); high while backlog != 0.
- REF_URGENT  out  1  backlog >= URGENT_LVL.
- MRS_REQ  out  1  mode-register-set request (level).
- SDRAM_RDY  out  1  initialisation complete; CPU cycles may be accepted.
- REF_OVF  out  1  sticky: a tick arrived with backlog already at MAX_PEND.
- PEND_CNT  out  4  current backlog count (debug/verification).

Behaviour:
- Reset (RESETn low at a clock edge) returns the block to PWR_WAIT, from any state:
  - wait counter and interval counter = 0, backlog = 0.
  - all outputs low.
  - Reset mid-init or mid-run restarts the full power-up sequence.
- FSM states: PWR_WAIT, INIT_PRE, INIT_REF, INIT_MRS, RUN.
  - PWR_WAIT: wait counter increments each clock. At count == INIT_WAIT-1, go to INIT_PRE next edge.
  - INIT_PRE: PRE_REQ high. On PRE_ACK, go to INIT_REF and load backlog = INIT_REFRESHES.
  - INIT_REF: REF_REQ from the backlog. Each REF_ACK decrements. When the backlog reaches 0, go to INIT_MRS.
  - INIT_MRS: MRS_REQ high. On MRS_ACK, go to RUN.
  - RUN: SDRAM_RDY high; it stays high until reset.
- Requests are level-held until acknowledged.
- PRE_REQ/MRS_REQ drop the cycle after their ack, i.e. they are decoded from state.
- Acks are ignored when the corresponding request is low or the FSM is in the wrong state.
- Interval counter:
  - Runs only in RUN; starts at 0 on entry to RUN.
  - Counts 0..REF_INTERVAL-1 and wraps.
  - Tick = counter at REF_INTERVAL-1; backlog updates on that same edge.
  - First tick occurs REF_INTERVAL clocks after entering RUN.
- Backlog update rules:
  - tick only: +1.
  - REF_ACK only, backlog > 0: -1.
  - tick and REF_ACK in the same cycle: unchanged.
  - REF_ACK at backlog 0: ignored, no underflow.
  - tick at MAX_PEND with no REF_ACK: backlog saturates at MAX_PEND and REF_OVF sets. REF_OVF clears only on reset.
- REF_REQ, REF_URGENT and PEND_CNT are decoded from registered state only; there is no combinational path from any input.
- REF_ACK pulses on consecutive cycles are legal; each one counts.
- Widths:
  - wait counter: ceil(log2(INIT_WAIT)) bits.
  - interval counter: ceil(log2(REF_INTERVAL)) bits.
  - backlog: 4 bits; MAX_PEND <= 15 and INIT_REFRESHES <= 15 are required.

Decomposition:
- Shared package u400_pkg holds:
  - FSM state enum (PWR_WAIT..RUN).
  - default timing constants in clocks at 40 MHz (INIT_WAIT, REF_INTERVAL).
  - SDRAM command encoding, reused by the sequencer.
- One natural sub-module, u400_ref_backlog: saturating up/down backlog counter with overflow flag, urgency compare and PEND_CNT.
- The interval counter and FSM stay in the parent.

Test Plan:
All scenarios use INIT_WAIT=20, REF_INTERVAL=10, INIT_REFRESHES=8, MAX_PEND=8, URGENT_LVL=6.
- Power-up: release reset, no acks.
  - PRE_REQ rises exactly 20 clocks after reset release.
  - All other outputs stay 0.
- Init: PRE_ACK, then 8 REF_ACK pulses on consecutive cycles, then MRS_ACK.
  - PEND_CNT goes 8..0.
  - MRS_REQ asserts after the 8th ack.
  - SDRAM_RDY rises the cycle after MRS_ACK.
- Periodic refresh in RUN: no acks.
  - Ticks every 10 clocks; PEND_CNT = 1, 2, 3...
  - REF_URGENT rises when PEND_CNT = 6.
  - 9th tick sets REF_OVF; PEND_CNT stays 8.
- Simultaneous events: REF_ACK coincident with a tick at PEND_CNT = 3.
  - PEND_CNT stays 3.
  - REF_ACK at PEND_CNT = 0 leaves it at 0 with no wrap.
- Spurious acks: MRS_ACK during PWR_WAIT and REF_ACK during INIT_PRE.
  - No state change; PRE_REQ timing unchanged.
- Mid-operation reset: assert RESETn low for 1 clock in RUN with PEND_CNT = 5 and REF_OVF = 1.
  - All outputs return to 0.
  - PRE_REQ re-asserts 20 clocks after release.
